// File: rtl/binary_morph_3x3_if.sv
// Video bus for the morphology stage: syncs plus the three colour channels.
// The master drives the bus and the slave receives it.
interface binary_morph_3x3_if;
   logic       vs;
   logic       hs;
   logic       de;
   logic [7:0] rgb_r;
   logic [7:0] rgb_g;
   logic [7:0] rgb_b;

   modport master (output vs, hs, de, rgb_r, rgb_g, rgb_b);
   modport slave  (input  vs, hs, de, rgb_r, rgb_g, rgb_b);
endinterface

// File: rtl/binary_morph_3x3.sv
// 3x3 binary erosion/dilation on a thresholded 0/255 video stream.
// Uses a causal window, so each result appears one line down and one pixel right.
module binary_morph_3x3 #(
   parameter int         MAX_WIDTH = 1920,
   parameter bit         MORPH_OP  = 1'b0,
   parameter logic [7:0] MODE_CODE = 8'h05
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [7:0]                 image_mode_i,
   binary_morph_3x3_if.slave          in_bus,
   binary_morph_3x3_if.master         out_bus
);
   localparam int             CW      = $clog2(MAX_WIDTH);
   localparam logic [CW-1:0]  COL_MAX = CW'(MAX_WIDTH - 1);
   localparam logic [1:0]     LC_FULL = 2'd2;

   logic          vs_prev_q, vs_prev_d;
   logic          de_prev_q, de_prev_d;
   logic [7:0]    mode_q, mode_d;
   logic [CW-1:0] col_q, col_d;
   logic [1:0]    lc_q, lc_d;

   logic [2:0]    s1_bits_q, s1_bits_d;
   logic [2:0]    s1_sync_q, s1_sync_d;
   logic          s1_ge1_q, s1_ge1_d;
   logic          s1_ge2_q, s1_ge2_d;
   logic [2:0]    c0_q, c1_q, c2_q;
   logic [2:0]    c0_d, c1_d, c2_d;
   logic [2:0]    s2_sync_q, s2_sync_d;
   logic          s2_ge1_q, s2_ge1_d;
   logic          s2_ge2_q, s2_ge2_d;
   logic          s3_res_q, s3_res_d;
   logic [2:0]    s3_sync_q, s3_sync_d;

   logic          lb1_q [MAX_WIDTH];
   logic          lb2_q [MAX_WIDTH];

   logic          vs_rise, de_fall, pix, rows_ok, lb1_rd, lb2_rd;
   logic [1:0]    lc_eff;
   logic [8:0]    window;
   logic          enabled;
   logic [7:0]    res_pix;

   // A vs rise on the same cycle as a pixel clears the line count first, so that pixel is row 0.
   always_comb begin
      vs_rise   = in_bus.vs & ~vs_prev_q;
      de_fall   = de_prev_q & ~in_bus.de;
      pix       = in_bus.rgb_r[7];
      lc_eff    = vs_rise ? 2'd0 : lc_q;
      rows_ok   = (lc_eff == LC_FULL);
      lb1_rd    = lb1_q[col_q];
      lb2_rd    = lb2_q[col_q];

      vs_prev_d = in_bus.vs;
      de_prev_d = in_bus.de;
      mode_d    = vs_rise ? image_mode_i : mode_q;
      lc_d      = lc_eff;
      if (!vs_rise && de_fall && (lc_q != LC_FULL)) begin
         lc_d = lc_q + 2'd1;
      end
      col_d = '0;
      if (in_bus.de) begin
         col_d = (col_q == COL_MAX) ? col_q : col_q + CW'(1);
      end

      s1_bits_d = in_bus.de ? {lb2_rd & rows_ok, lb1_rd & rows_ok, pix} : 3'b000;
      s1_sync_d = {in_bus.vs, in_bus.hs, in_bus.de};
      s1_ge1_d  = (col_q != '0);
      s1_ge2_d  = (col_q >= CW'(2));

      c0_d      = s1_bits_q;
      c1_d      = c0_q;
      c2_d      = c1_q;
      s2_sync_d = s1_sync_q;
      s2_ge1_d  = s1_ge1_q;
      s2_ge2_d  = s1_ge2_q;

      // Columns left of the line start do not exist and contribute zeros.
      window    = {c2_q & {3{s2_ge2_q}}, c1_q & {3{s2_ge1_q}}, c0_q};
      s3_res_d  = MORPH_OP ? (|window) : (&window);
      s3_sync_d = s2_sync_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         vs_prev_q <= 1'b0;
         de_prev_q <= 1'b0;
         mode_q    <= 8'h00;
         col_q     <= '0;
         lc_q      <= 2'd0;
         s1_bits_q <= 3'b000;
         s1_sync_q <= 3'b000;
         s1_ge1_q  <= 1'b0;
         s1_ge2_q  <= 1'b0;
         c0_q      <= 3'b000;
         c1_q      <= 3'b000;
         c2_q      <= 3'b000;
         s2_sync_q <= 3'b000;
         s2_ge1_q  <= 1'b0;
         s2_ge2_q  <= 1'b0;
         s3_res_q  <= 1'b0;
         s3_sync_q <= 3'b000;
      end else begin
         vs_prev_q <= vs_prev_d;
         de_prev_q <= de_prev_d;
         mode_q    <= mode_d;
         col_q     <= col_d;
         lc_q      <= lc_d;
         s1_bits_q <= s1_bits_d;
         s1_sync_q <= s1_sync_d;
         s1_ge1_q  <= s1_ge1_d;
         s1_ge2_q  <= s1_ge2_d;
         c0_q      <= c0_d;
         c1_q      <= c1_d;
         c2_q      <= c2_d;
         s2_sync_q <= s2_sync_d;
         s2_ge1_q  <= s2_ge1_d;
         s2_ge2_q  <= s2_ge2_d;
         s3_res_q  <= s3_res_d;
         s3_sync_q <= s3_sync_d;
      end
   end

   // Line buffers hold no reset: stale contents are masked until two lines have arrived.
   always_ff @(posedge clock) begin
      if (in_bus.de) begin
         lb1_q[col_q] <= pix;
         lb2_q[col_q] <= lb1_rd;
      end
   end

   always_comb begin
      enabled = (mode_q == MODE_CODE) && !reset;
      res_pix = (s3_sync_q[0] && s3_res_q) ? 8'd255 : 8'd0;
      if (enabled) begin
         out_bus.vs    = s3_sync_q[2];
         out_bus.hs    = s3_sync_q[1];
         out_bus.de    = s3_sync_q[0];
         out_bus.rgb_r = res_pix;
         out_bus.rgb_g = res_pix;
         out_bus.rgb_b = res_pix;
      end else begin
         out_bus.vs    = in_bus.vs;
         out_bus.hs    = in_bus.hs;
         out_bus.de    = in_bus.de;
         out_bus.rgb_r = in_bus.rgb_r;
         out_bus.rgb_g = in_bus.rgb_g;
         out_bus.rgb_b = in_bus.rgb_b;
      end
   end
endmodule

// File: tb/tb_binary_morph_3x3.sv
// Scoreboard bench for binary_morph_3x3: an erosion and a dilation instance share one input stream
// and are checked every cycle against a window-level reference model of the frame.
module tb_binary_morph_3x3;
   localparam int W = 16;

   typedef struct {
      logic [26:0] e;
      logic [26:0] d;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] image_mode_i;
   int         tests_run = 0;
   int         tests_failed = 0;
   exp_t       sb_q[$];

   // Reference model state: latched mode, row/column position, received image, output delay line.
   logic [7:0]  m_mode;
   bit          m_vs_prev, m_de_prev;
   int          m_y, m_col;
   bit          m_img[16][W];
   bit          m_hist[$];
   logic [26:0] m_pipe_e[3];
   logic [26:0] m_pipe_d[3];

   binary_morph_3x3_if in_bus();
   binary_morph_3x3_if out_e();
   binary_morph_3x3_if out_d();

   always #5 clock = ~clock;

   binary_morph_3x3 #(.MAX_WIDTH(W), .MORPH_OP(1'b0), .MODE_CODE(8'h05)) u_dut_e (
      .clock(clock), .reset(reset), .image_mode_i(image_mode_i), .in_bus(in_bus), .out_bus(out_e));
   binary_morph_3x3 #(.MAX_WIDTH(W), .MORPH_OP(1'b1), .MODE_CODE(8'h05)) u_dut_d (
      .clock(clock), .reset(reset), .image_mode_i(image_mode_i), .in_bus(in_bus), .out_bus(out_d));

   task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("[TB] FAIL %s got %h want %h", name, got, want);
      end
   endtask

   // One clock of stimulus: compute the expected bus for this cycle, then advance the model at the edge.
   task automatic apply_stimulus(input bit rst, input bit vs, input bit hs, input bit de,
                                 input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      bit          vs_rise, p, res_e, res_d, val;
      int          yeff;
      logic [7:0]  oe, od;
      logic [26:0] en_e, en_d, byp;
      exp_t        x;
      reset = rst;
      in_bus.vs = vs; in_bus.hs = hs; in_bus.de = de;
      in_bus.rgb_r = r; in_bus.rgb_g = g; in_bus.rgb_b = b;

      vs_rise = vs && !m_vs_prev;
      yeff    = vs_rise ? 0 : m_y;
      p       = (r >= 8'd128);
      res_e   = 1'b1;
      res_d   = 1'b0;
      if (de) begin
         for (int dx = 0; dx < 3; dx++) begin
            for (int dy = 0; dy < 3; dy++) begin
               val = 1'b0;
               if ((m_col >= dx) && (dy == 0 || yeff >= 2)) begin
                  if (dy == 0) val = (dx == 0) ? p : m_hist[m_hist.size() - dx];
                  else         val = m_img[yeff - dy][m_col - dx];
               end
               res_e = res_e & val;
               res_d = res_d | val;
            end
         end
      end
      oe   = (de && res_e) ? 8'hFF : 8'h00;
      od   = (de && res_d) ? 8'hFF : 8'h00;
      en_e = {vs, hs, de, oe, oe, oe};
      en_d = {vs, hs, de, od, od, od};
      byp  = {vs, hs, de, r, g, b};
      x.e  = (rst || m_mode != 8'h05) ? byp : m_pipe_e[2];
      x.d  = (rst || m_mode != 8'h05) ? byp : m_pipe_d[2];
      sb_q.push_back(x);

      @(posedge clock);
      if (rst) begin
         m_mode = 8'h00; m_vs_prev = 0; m_de_prev = 0; m_y = 0; m_col = 0;
         m_hist.delete();
         for (int i = 0; i < 3; i++) begin
            m_pipe_e[i] = '0;
            m_pipe_d[i] = '0;
         end
      end else begin
         if (vs_rise) m_mode = image_mode_i;
         if (de) begin
            if (yeff < 16) m_img[yeff][m_col] = p;
            m_hist.push_back(p);
            if (m_col < W - 1) m_col++;
         end else begin
            m_col = 0;
            m_hist.delete();
         end
         if (vs_rise) m_y = 0;
         else if (m_de_prev && !de && m_y < 15) m_y++;
         m_vs_prev = vs;
         m_de_prev = de;
         m_pipe_e[2] = m_pipe_e[1]; m_pipe_e[1] = m_pipe_e[0]; m_pipe_e[0] = en_e;
         m_pipe_d[2] = m_pipe_d[1]; m_pipe_d[1] = m_pipe_d[0]; m_pipe_d[0] = en_d;
      end
      #1;
   endtask

   // kind: 0 all white, 1 single white pixel at (4,3), 2 random levels.
   task automatic send_frame(input int w, input int h, input int kind, input bit vs_with_de,
                             input int switch_line, input int rst_line, input int rst_px);
      logic [7:0] r;
      bit         vs;
      repeat (2) apply_stimulus(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
      if (!vs_with_de) begin
         repeat (2) apply_stimulus(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
         apply_stimulus(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
      end
      for (int y = 0; y < h; y++) begin
         if (y == switch_line) image_mode_i = 8'h05;
         for (int x = 0; x < w; x++) begin
            case (kind)
               0:       r = 8'd255;
               1:       r = (x == 4 && y == 3) ? 8'd255 : 8'd0;
               default: r = 8'($urandom_range(0, 255));
            endcase
            vs = vs_with_de && (y == 0) && (x == 0);
            apply_stimulus((y == rst_line) && (x == rst_px), vs, 0, 1, r,
                           8'($urandom), 8'($urandom));
         end
         if (w > W) check_output("col_saturate", 32'(u_dut_e.col_q), 32'(W - 1));
         apply_stimulus(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
         apply_stimulus(0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
         apply_stimulus(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
      end
      repeat (4) apply_stimulus(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
   endtask

   // Monitor: every cycle the DUTs present a bus value, compare it with the oldest expectation.
   initial begin
      exp_t x;
      forever begin
         @(negedge clock);
         if (sb_q.size() != 0) begin
            x = sb_q.pop_front();
            check_output("bus_erode",
                         {5'b0, out_e.vs, out_e.hs, out_e.de, out_e.rgb_r, out_e.rgb_g, out_e.rgb_b},
                         {5'b0, x.e});
            check_output("bus_dilate",
                         {5'b0, out_d.vs, out_d.hs, out_d.de, out_d.rgb_r, out_d.rgb_g, out_d.rgb_b},
                         {5'b0, x.d});
         end
      end
   end

   initial begin
      reset = 1'b1;
      image_mode_i = 8'h00;
      in_bus.vs = 0; in_bus.hs = 0; in_bus.de = 0;
      in_bus.rgb_r = 0; in_bus.rgb_g = 0; in_bus.rgb_b = 0;
      m_mode = 0; m_vs_prev = 0; m_de_prev = 0; m_y = 0; m_col = 0;
      for (int i = 0; i < 3; i++) begin
         m_pipe_e[i] = '0;
         m_pipe_d[i] = '0;
      end
      @(posedge clock);
      #1;
      repeat (3) apply_stimulus(1, 0, 0, 0, 8'h00, 8'h00, 8'h00);

      $display("[TB] bypass with random syncs and colours");
      for (int i = 0; i < 40; i++) begin
         apply_stimulus(0, 1'($urandom), 1'($urandom), 1'($urandom),
                        8'($urandom), 8'($urandom), 8'($urandom));
      end

      $display("[TB] filtered frames: all white, single pixel");
      image_mode_i = 8'h05;
      send_frame(8, 6, 0, 0, -1, -1, -1);
      send_frame(10, 6, 1, 0, -1, -1, -1);

      $display("[TB] mode change mid-frame");
      image_mode_i = 8'h00;
      send_frame(8, 4, 2, 0, 2, -1, -1);
      send_frame(8, 4, 2, 0, -1, -1, -1);

      $display("[TB] random frames");
      for (int i = 0; i < 4; i++) begin
         send_frame($urandom_range(3, 12), $urandom_range(3, 7), 2, 1'($urandom), -1, -1, -1);
      end

      $display("[TB] overlong line and mid-line reset");
      send_frame(W + 4, 1, 2, 0, -1, -1, -1);
      send_frame(8, 4, 2, 0, -1, 2, 3);
      send_frame(8, 4, 2, 0, -1, -1, -1);

      for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clock);
      if (sb_q.size() != 0) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
